axis_frame_arbiter: RTL and testbench
=====================================

// Module: axis_frame_arbiter
// PURPOSE
//  Shares one AXI4-Stream video output (VDMA MM2S style: tuser=SOF, tlast=EOL) between two frame sources.
//  Arbitrates round-robin at frame granularity only, so a granted frame is never split or interleaved.
//  Sits between two axis_master-class frame generators/VDMAs and the single downstream video consumer.
//  Also flushes out-of-sync beats and flags line-length and SOF protocol errors.
// PARAMETERS
//  S_AXIS_TDATA_WIDTH  64    tdata width, all ports
//  VDMA_ROW            2160  lines per frame (tlast count); >=1
//  VDMA_COLUMN         3840  beats per line; >=1
// PORTS
//  s_axis_aclk          in   1    single clock
//  s_axis_areset        in   1    synchronous reset, active-high
//  src_en               in   2    per-source enable; a disabled source is never granted
//  err_clr              in   1    clears both sticky error flags
//  s0_axis_mm2s_tdata   in   W    source 0 data (W = S_AXIS_TDATA_WIDTH)
//  s0_axis_mm2s_tvalid  in   1    source 0 valid
//  s0_axis_mm2s_tready  out  1    source 0 ready
//  s0_axis_mm2s_tuser   in   1    source 0 SOF
//  s0_axis_mm2s_tlast   in   1    source 0 EOL
//  s1_axis_mm2s_*       -    -    source 1, same set as s0
//  m_axis_mm2s_tdata    out  W    output data
//  m_axis_mm2s_tvalid   out  1    output valid
//  m_axis_mm2s_tready   in   1    output ready
//  m_axis_mm2s_tuser    out  1    output SOF
//  m_axis_mm2s_tlast    out  1    output EOL
//  grant                out  2    one-hot active source; 2'b00 when idle
//  frame_done           out  1    1-cycle pulse after the last EOL of a granted frame
//  err_eol              out  1    sticky: tlast on a beat other than column VDMA_COLUMN-1, or missing at that column
//  err_sof              out  1    sticky: tuser on a beat other than the first beat of a frame
// BEHAVIOUR
//  Reset: state IDLE, grant=0, last_grant=1 (src0 wins first), counters 0, flags 0, frame_done 0, all tready 0.
//  m_axis_mm2s_tvalid is 0 whenever grant=0.
//  FSM states: IDLE, BUSY.
//  IDLE:
//   - Any enabled source with tvalid=1 and tuser=0 gets tready=1; the beat is dropped (flush).
//   - A source presenting tvalid & tuser is held: tready=0, beat not consumed.
//   - Candidates are enabled sources holding an SOF beat.
//   - One candidate: grant it. Two candidates: grant the source != last_grant.
//   - grant registers; goes BUSY next cycle.
//   - Decision cycle N -> SOF beat forwarded from cycle N+1.
//  BUSY:
//   - Combinational pass-through, zero latency: m_* = granted s*_*, granted tready = m_axis_mm2s_tready.
//   - Non-granted tready = 0.
//   - col_cnt advances on each output handshake; row_cnt advances on each handshake with tlast.
//   - Handshake with tlast:
//       col_cnt != VDMA_COLUMN-1 -> err_eol=1.
//       Always col_cnt <= 0, row_cnt++ (tlast resyncs the line).
//   - Handshake with col_cnt==VDMA_COLUMN-1 and tlast=0 -> err_eol=1; col_cnt wraps to 0, row_cnt unchanged.
//   - Handshake with tuser=1 and (row_cnt,col_cnt)!=(0,0) -> err_sof=1; counters restart as a new frame, grant kept.
//   - Handshake with tlast and row_cnt==VDMA_ROW-1:
//       next cycle: state IDLE, grant=0, last_grant=granted source, frame_done=1 for 1 cycle.
//   - src_en of the granted source dropping mid-frame has no effect until the frame completes.
//  Errors: err_clr clears both flags. A new error in the same cycle as err_clr wins (flag stays 1).
//  Counters: col_cnt sized clog2(VDMA_COLUMN), row_cnt sized clog2(VDMA_ROW); width >=1 when param=1.
//  Reset mid-frame: returns to IDLE immediately. The remainder of the partial frame is flushed as non-SOF beats.
// TESTING (bench params VDMA_ROW=4, VDMA_COLUMN=8, W=64, tready=1 unless stated)
//  1 src_en=01, src0 sends 2 frames -> 64 beats out unchanged; 2 frame_done pulses; grant=01 during frames, 00 for >=1 cycle between.
//  2 src_en=11, both hold SOF from reset -> frames alternate src0,src1,src0.
//     The waiting source's tready stays 0 until the other's last EOL.
//  3 src1 sends 5 non-SOF beats then an SOF frame -> 5 beats flushed (tready=1, m_tvalid=0); then a 32-beat frame out.
//  4 src0 asserts tlast at column 5 of line 1 -> err_eol=1.
//     Frame ends after 4 tlasts total (30 beats); err_clr pulse -> err_eol=0.
//  5 Random m_axis_mm2s_tready (50%) on scenario 2 -> no beat lost or duplicated; tuser/tlast positions preserved.
//  6 Assert s_axis_areset at beat 10 of a src0 frame -> next cycle grant=0, all tready=0.
//     After release, src0's remaining 22 beats are flushed; next SOF is granted normally.

Source files
------------

// File: rtl/axis_frame_arbiter.sv
// Two-source AXI4-Stream video arbiter with frame-granular round-robin grant.
// Flushes unframed beats while idle and flags line-length / SOF protocol errors.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no grant; non-SOF beats are drained, SOF beats held for arbitration
// BUSY  | granted source passed straight through until its last EOL
module axis_frame_arbiter #(
    parameter int S_AXIS_TDATA_WIDTH = 64,
    parameter int VDMA_ROW           = 2160,
    parameter int VDMA_COLUMN        = 3840
) (
    input  logic                          s_axis_aclk,
    input  logic                          s_axis_areset,
    input  logic [1:0]                    src_en,
    input  logic                          err_clr,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] s0_axis_mm2s_tdata,
    input  logic                          s0_axis_mm2s_tvalid,
    output logic                          s0_axis_mm2s_tready,
    input  logic                          s0_axis_mm2s_tuser,
    input  logic                          s0_axis_mm2s_tlast,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] s1_axis_mm2s_tdata,
    input  logic                          s1_axis_mm2s_tvalid,
    output logic                          s1_axis_mm2s_tready,
    input  logic                          s1_axis_mm2s_tuser,
    input  logic                          s1_axis_mm2s_tlast,
    output logic [S_AXIS_TDATA_WIDTH-1:0] m_axis_mm2s_tdata,
    output logic                          m_axis_mm2s_tvalid,
    input  logic                          m_axis_mm2s_tready,
    output logic                          m_axis_mm2s_tuser,
    output logic                          m_axis_mm2s_tlast,
    output logic [1:0]                    grant,
    output logic                          frame_done,
    output logic                          err_eol,
    output logic                          err_sof
);

    localparam int CW = (VDMA_COLUMN > 1) ? $clog2(VDMA_COLUMN) : 1;
    localparam int RW = (VDMA_ROW > 1) ? $clog2(VDMA_ROW) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(VDMA_COLUMN - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(VDMA_ROW - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nxt;
    logic [1:0]    grant_nxt;
    logic          last_grant, last_grant_nxt;
    logic [CW-1:0] col_cnt, col_nxt, eff_col;
    logic [RW-1:0] row_cnt, row_nxt, eff_row;
    logic          frame_done_nxt;
    logic          eol_evt, sof_evt;
    logic [1:0]    cand;

    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_grant <= 1'b1;
            col_cnt    <= '0;
            row_cnt    <= '0;
            frame_done <= 1'b0;
            err_eol    <= 1'b0;
            err_sof    <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            col_cnt    <= col_nxt;
            row_cnt    <= row_nxt;
            frame_done <= frame_done_nxt;
            // a fresh error in the clear cycle must survive the clear
            err_eol    <= (err_eol & ~err_clr) | eol_evt;
            err_sof    <= (err_sof & ~err_clr) | sof_evt;
        end
    end

    always_comb begin
        state_nxt           = state;
        grant_nxt           = grant;
        last_grant_nxt      = last_grant;
        col_nxt             = col_cnt;
        row_nxt             = row_cnt;
        eff_col             = col_cnt;
        eff_row             = row_cnt;
        frame_done_nxt      = 1'b0;
        eol_evt             = 1'b0;
        sof_evt             = 1'b0;
        cand                = 2'b00;
        s0_axis_mm2s_tready = 1'b0;
        s1_axis_mm2s_tready = 1'b0;
        m_axis_mm2s_tdata   = '0;
        m_axis_mm2s_tvalid  = 1'b0;
        m_axis_mm2s_tuser   = 1'b0;
        m_axis_mm2s_tlast   = 1'b0;
        if (!s_axis_areset) begin
            case (state)
                IDLE: begin
                    s0_axis_mm2s_tready = src_en[0] & s0_axis_mm2s_tvalid & ~s0_axis_mm2s_tuser;
                    s1_axis_mm2s_tready = src_en[1] & s1_axis_mm2s_tvalid & ~s1_axis_mm2s_tuser;
                    cand = {src_en[1] & s1_axis_mm2s_tvalid & s1_axis_mm2s_tuser,
                            src_en[0] & s0_axis_mm2s_tvalid & s0_axis_mm2s_tuser};
                    col_nxt = '0;
                    row_nxt = '0;
                    if (cand[0] && (!cand[1] || last_grant)) begin
                        grant_nxt = 2'b01;
                        state_nxt = BUSY;
                    end else if (cand[1]) begin
                        grant_nxt = 2'b10;
                        state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    if (grant[1]) begin
                        m_axis_mm2s_tdata   = s1_axis_mm2s_tdata;
                        m_axis_mm2s_tvalid  = s1_axis_mm2s_tvalid;
                        m_axis_mm2s_tuser   = s1_axis_mm2s_tuser;
                        m_axis_mm2s_tlast   = s1_axis_mm2s_tlast;
                        s1_axis_mm2s_tready = m_axis_mm2s_tready;
                    end else begin
                        m_axis_mm2s_tdata   = s0_axis_mm2s_tdata;
                        m_axis_mm2s_tvalid  = s0_axis_mm2s_tvalid;
                        m_axis_mm2s_tuser   = s0_axis_mm2s_tuser;
                        m_axis_mm2s_tlast   = s0_axis_mm2s_tlast;
                        s0_axis_mm2s_tready = m_axis_mm2s_tready;
                    end
                    if (m_axis_mm2s_tvalid && m_axis_mm2s_tready) begin
                        // an SOF always restarts the frame position, misplaced or not
                        if (m_axis_mm2s_tuser) begin
                            sof_evt = (row_cnt != '0) || (col_cnt != '0);
                            eff_col = '0;
                            eff_row = '0;
                        end
                        if (m_axis_mm2s_tlast) begin
                            eol_evt = (eff_col != COL_LAST);
                            col_nxt = '0;
                            if (eff_row == ROW_LAST) begin
                                row_nxt        = '0;
                                state_nxt      = IDLE;
                                grant_nxt      = 2'b00;
                                last_grant_nxt = grant[1];
                                frame_done_nxt = 1'b1;
                            end else begin
                                row_nxt = eff_row + RW'(1);
                            end
                        end else if (eff_col == COL_LAST) begin
                            eol_evt = 1'b1;
                            col_nxt = '0;
                            row_nxt = eff_row;
                        end else begin
                            col_nxt = eff_col + CW'(1);
                            row_nxt = eff_row;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// Directed bench for axis_frame_arbiter: queued source models, captured output
// stream compared against a bench-built expected stream.
module tb_axis_frame_arbiter;

    localparam int W   = 64;
    localparam int ROW = 4;
    localparam int COL = 8;

    typedef struct packed {
        logic [W-1:0] data;
        logic         user;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         s_axis_areset;
    logic [1:0]   src_en;
    logic         err_clr;
    logic [W-1:0] s0_tdata, s1_tdata, m_tdata;
    logic         s0_tvalid, s0_tready, s0_tuser, s0_tlast;
    logic         s1_tvalid, s1_tready, s1_tuser, s1_tlast;
    logic         m_tvalid, m_tready, m_tuser, m_tlast;
    logic [1:0]   grant;
    logic         frame_done, err_eol, err_sof;

    beat_t      q0[$], q1[$], outq[$], expq[$];
    logic [1:0] outg[$], expg[$];
    int         flush0, flush1, fd_cnt, fd_bad, idle_bad, wait_bad;
    int         checks = 0;
    int         failures = 0;
    bit         rnd_mode = 1'b0;

    always #5 clk = ~clk;

    axis_frame_arbiter #(
        .S_AXIS_TDATA_WIDTH(W),
        .VDMA_ROW(ROW),
        .VDMA_COLUMN(COL)
    ) dut (
        .s_axis_aclk(clk),
        .s_axis_areset(s_axis_areset),
        .src_en(src_en),
        .err_clr(err_clr),
        .s0_axis_mm2s_tdata(s0_tdata),
        .s0_axis_mm2s_tvalid(s0_tvalid),
        .s0_axis_mm2s_tready(s0_tready),
        .s0_axis_mm2s_tuser(s0_tuser),
        .s0_axis_mm2s_tlast(s0_tlast),
        .s1_axis_mm2s_tdata(s1_tdata),
        .s1_axis_mm2s_tvalid(s1_tvalid),
        .s1_axis_mm2s_tready(s1_tready),
        .s1_axis_mm2s_tuser(s1_tuser),
        .s1_axis_mm2s_tlast(s1_tlast),
        .m_axis_mm2s_tdata(m_tdata),
        .m_axis_mm2s_tvalid(m_tvalid),
        .m_axis_mm2s_tready(m_tready),
        .m_axis_mm2s_tuser(m_tuser),
        .m_axis_mm2s_tlast(m_tlast),
        .grant(grant),
        .frame_done(frame_done),
        .err_eol(err_eol),
        .err_sof(err_sof)
    );

    function automatic beat_t mk(input int src, input int fid, input int r, input int c,
                                 input logic u, input logic l);
        beat_t b;
        b.data = {8'(src), 8'(fid), 16'(r), 16'(c), 16'hA5C3};
        b.user = u;
        b.last = l;
        return b;
    endfunction

    task automatic push_beat(input int src, input beat_t b, input bit to_exp);
        if (src == 0) q0.push_back(b);
        else q1.push_back(b);
        if (to_exp) begin
            expq.push_back(b);
            expg.push_back(src == 0 ? 2'b01 : 2'b10);
        end
    endtask

    // short_row selects one line of length short_len (tlast placed early)
    task automatic push_frame(input int src, input int fid, input int short_row = -1,
                              input int short_len = 0, input bit to_exp = 1'b1);
        for (int r = 0; r < ROW; r++) begin
            int len;
            len = (r == short_row) ? short_len : COL;
            for (int c = 0; c < len; c++)
                push_beat(src, mk(src, fid, r, c, (r == 0 && c == 0), (c == len - 1)), to_exp);
        end
    endtask

    task automatic drive();
        s0_tvalid = (q0.size() > 0);
        s0_tdata  = s0_tvalid ? q0[0].data : '0;
        s0_tuser  = s0_tvalid ? q0[0].user : 1'b0;
        s0_tlast  = s0_tvalid ? q0[0].last : 1'b0;
        s1_tvalid = (q1.size() > 0);
        s1_tdata  = s1_tvalid ? q1[0].data : '0;
        s1_tuser  = s1_tvalid ? q1[0].user : 1'b0;
        s1_tlast  = s1_tvalid ? q1[0].last : 1'b0;
        m_tready  = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // one clock: observe at negedge, advance source queues after the edge
    task automatic step();
        bit hs0, hs1, hsm;
        @(negedge clk);
        hs0 = s0_tvalid && s0_tready;
        hs1 = s1_tvalid && s1_tready;
        hsm = m_tvalid && m_tready;
        if (frame_done) begin
            fd_cnt++;
            if (grant != 2'b00) fd_bad++;
        end
        if (m_tvalid && grant == 2'b00) idle_bad++;
        if ((grant == 2'b01 && s1_tready) || (grant == 2'b10 && s0_tready)) wait_bad++;
        if (hsm) begin
            outq.push_back({m_tdata, m_tuser, m_tlast});
            outg.push_back(grant);
        end
        if (hs0 && grant != 2'b01) flush0++;
        if (hs1 && grant != 2'b10) flush1++;
        @(posedge clk);
        #1;
        if (hs0) void'(q0.pop_front());
        if (hs1) void'(q1.pop_front());
        drive();
    endtask

    task automatic run_until(input int n, input int budget, output bit ok);
        int cyc;
        cyc = 0;
        while (outq.size() < n && cyc < budget) begin
            step();
            cyc++;
        end
        ok = (outq.size() >= n);
    endtask

    task automatic stream_diff(output int bad);
        int n;
        bad = (outq.size() != expq.size()) ? 1 : 0;
        n = (outq.size() < expq.size()) ? outq.size() : expq.size();
        for (int i = 0; i < n; i++)
            if (outq[i] !== expq[i] || outg[i] !== expg[i]) bad++;
    endtask

    task automatic apply_reset();
        q0.delete(); q1.delete(); outq.delete(); expq.delete(); outg.delete(); expg.delete();
        err_clr = 1'b0;
        rnd_mode = 1'b0;
        s_axis_areset = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        s_axis_areset = 1'b0;
        flush0 = 0; flush1 = 0; fd_cnt = 0; fd_bad = 0; idle_bad = 0; wait_bad = 0;
    endtask

    task automatic test_reset();
        q0.delete(); q1.delete();
        src_en = 2'b11;
        err_clr = 1'b0;
        s_axis_areset = 1'b1;
        push_beat(0, mk(0, 0, 1, 1, 1'b0, 1'b0), 1'b0);
        drive();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (grant !== 2'b00) begin failures++; $display("FAIL reset_grant got=%b exp=00", grant); end
        checks++; if (s0_tready !== 1'b0 || s1_tready !== 1'b0) begin failures++; $display("FAIL reset_tready got=%b%b exp=00", s1_tready, s0_tready); end
        checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL reset_m_tvalid got=%b exp=0", m_tvalid); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        checks++; if (err_eol !== 1'b0 || err_sof !== 1'b0) begin failures++; $display("FAIL reset_errs got=eol%b sof%b exp=0 0", err_eol, err_sof); end
        s_axis_areset = 1'b0;
    endtask

    task automatic test_single_source();
        bit ok;
        int bad;
        apply_reset();
        src_en = 2'b01;
        push_frame(0, 0);
        push_frame(0, 1);
        drive();
        checks++; if ({grant, s0_tready} !== 3'b000) begin failures++; $display("FAIL sof_hold got grant=%b tready=%b exp grant=00 tready=0", grant, s0_tready); end
        step();
        checks++; if ({grant, m_tvalid, m_tuser} !== 4'b0111) begin failures++; $display("FAIL grant_latency got grant=%b tvalid=%b tuser=%b exp 01 1 1", grant, m_tvalid, m_tuser); end
        run_until(64, 300, ok);
        repeat (3) step();
        checks++; if (!ok) begin failures++; $display("FAIL single_timeout got beats=%0d exp=64", outq.size()); end
        stream_diff(bad);
        checks++; if (bad != 0) begin failures++; $display("FAIL single_stream got mismatches=%0d exp=0", bad); end
        checks++; if (fd_cnt != 2) begin failures++; $display("FAIL single_frame_done got=%0d exp=2", fd_cnt); end
        checks++; if (fd_bad != 0 || idle_bad != 0) begin failures++; $display("FAIL single_idle_gap got fd_bad=%0d idle_valid=%0d exp 0 0", fd_bad, idle_bad); end
    endtask

    task automatic test_round_robin(input bit rnd);
        bit ok;
        int bad;
        apply_reset();
        rnd_mode = rnd;
        src_en = 2'b11;
        push_frame(0, 0);
        push_frame(1, 0);
        push_frame(0, 1);
        drive();
        run_until(96, rnd ? 1500 : 400, ok);
        repeat (3) step();
        checks++; if (!ok) begin failures++; $display("FAIL rr%0d_timeout got beats=%0d exp=96", rnd, outq.size()); end
        stream_diff(bad);
        checks++; if (bad != 0) begin failures++; $display("FAIL rr%0d_stream got mismatches=%0d exp=0", rnd, bad); end
        checks++; if (fd_cnt != 3) begin failures++; $display("FAIL rr%0d_frame_done got=%0d exp=3", rnd, fd_cnt); end
        checks++; if (wait_bad != 0) begin failures++; $display("FAIL rr%0d_waiting_tready got=%0d exp=0", rnd, wait_bad); end
    endtask

    task automatic test_flush();
        bit ok;
        int bad;
        apply_reset();
        src_en = 2'b11;
        for (int i = 0; i < 5; i++) push_beat(1, mk(1, 7, 2, i, 1'b0, (i == 4)), 1'b0);
        push_frame(1, 0);
        drive();
        run_until(32, 300, ok);
        repeat (3) step();
        checks++; if (flush1 != 5) begin failures++; $display("FAIL flush_count got=%0d exp=5", flush1); end
        stream_diff(bad);
        checks++; if (!ok || bad != 0) begin failures++; $display("FAIL flush_stream got beats=%0d mismatches=%0d exp 32 0", outq.size(), bad); end
        checks++; if (idle_bad != 0 || fd_cnt != 1) begin failures++; $display("FAIL flush_frame got idle_valid=%0d frame_done=%0d exp 0 1", idle_bad, fd_cnt); end
    endtask

    task automatic test_eol_error();
        bit ok;
        int bad;
        apply_reset();
        src_en = 2'b01;
        push_frame(0, 3, 1, 6);
        drive();
        run_until(30, 300, ok);
        repeat (3) step();
        stream_diff(bad);
        checks++; if (!ok || bad != 0 || fd_cnt != 1) begin failures++; $display("FAIL eol_frame got beats=%0d mismatches=%0d frame_done=%0d exp 30 0 1", outq.size(), bad, fd_cnt); end
        checks++; if (err_eol !== 1'b1 || err_sof !== 1'b0) begin failures++; $display("FAIL eol_flag got eol=%b sof=%b exp 1 0", err_eol, err_sof); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++; if (err_eol !== 1'b0) begin failures++; $display("FAIL eol_clear got=%b exp=0", err_eol); end
    endtask

    task automatic test_sof_error();
        bit ok;
        int bad;
        apply_reset();
        src_en = 2'b01;
        for (int c = 0; c < 3; c++) push_beat(0, mk(0, 9, 0, c, (c == 0), 1'b0), 1'b1);
        push_frame(0, 1);
        drive();
        run_until(35, 300, ok);
        repeat (3) step();
        stream_diff(bad);
        checks++; if (!ok || bad != 0 || fd_cnt != 1) begin failures++; $display("FAIL sof_frame got beats=%0d mismatches=%0d frame_done=%0d exp 35 0 1", outq.size(), bad, fd_cnt); end
        checks++; if (err_sof !== 1'b1 || err_eol !== 1'b0) begin failures++; $display("FAIL sof_flag got sof=%b eol=%b exp 1 0", err_sof, err_eol); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        int bad;
        apply_reset();
        src_en = 2'b01;
        push_frame(0, 0, -1, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            expq.push_back(q0[i]);
            expg.push_back(2'b01);
        end
        push_frame(0, 1);
        drive();
        run_until(10, 100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL midrst_timeout got beats=%0d exp=10", outq.size()); end
        s_axis_areset = 1'b1;
        step();
        checks++; if ({grant, s1_tready, s0_tready, m_tvalid} !== 5'b0) begin failures++; $display("FAIL midrst_state got grant=%b tready=%b%b tvalid=%b exp 00 00 0", grant, s1_tready, s0_tready, m_tvalid); end
        s_axis_areset = 1'b0;
        run_until(42, 300, ok);
        repeat (3) step();
        checks++; if (flush0 != 22) begin failures++; $display("FAIL midrst_flush got=%0d exp=22", flush0); end
        stream_diff(bad);
        checks++; if (!ok || bad != 0 || fd_cnt != 1) begin failures++; $display("FAIL midrst_stream got beats=%0d mismatches=%0d frame_done=%0d exp 42 0 1", outq.size(), bad, fd_cnt); end
    endtask

    initial begin
        s_axis_areset = 1'b1;
        src_en = 2'b00;
        err_clr = 1'b0;
        drive();
        test_reset();
        test_single_source();
        test_round_robin(1'b0);
        test_flush();
        test_eol_error();
        test_sof_error();
        test_round_robin(1'b1);
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
